// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: single-cycle logic/arith/shift ops,
// bus-cycle shift-add multiply and restoring divide.
module seq_alu #(
  parameter int bus = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [bus-1:0] a,
  input  logic [bus-1:0] b,
  input  logic [3:0]     ALUFUN,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [bus-1:0] s,
  output logic [3:0]     CNVZ,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int SW = $clog2(bus);

  localparam logic [3:0] OP_LSL  = 4'h0;
  localparam logic [3:0] OP_LSR  = 4'h1;
  localparam logic [3:0] OP_ASL  = 4'h2;
  localparam logic [3:0] OP_ASR  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hB;
  localparam logic [3:0] OP_MODU = 4'hC;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [bus-1:0]  opnd_q;
  logic [bus-1:0]  hi;
  logic [bus-1:0]  lo;
  logic [SW-1:0]   cnt;

  logic [SW-1:0]   shamt;
  logic [bus:0]    lsl_w, lsr_w, asr_w, add_w, sub_w;
  logic [bus-1:0]  sc_s;
  logic            sc_c, sc_v;
  logic            is_multi;

  assign shamt    = b[SW-1:0];
  assign is_multi = (ALUFUN == OP_MUL) || (ALUFUN == OP_DIVU) || (ALUFUN == OP_MODU);

  // Shifting one extra bit along with the operand leaves the last bit shifted
  // out in the spare position; a zero shift leaves a zero there.
  assign lsl_w = {1'b0, a} << shamt;
  assign lsr_w = {a, 1'b0} >> shamt;
  assign asr_w = $signed({a, 1'b0}) >>> shamt;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (bus+1)'(1);

  always_comb begin
    sc_s = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (ALUFUN)
      OP_LSL, OP_ASL: {sc_c, sc_s} = lsl_w;
      OP_LSR:         {sc_s, sc_c} = lsr_w;
      OP_ASR:         {sc_s, sc_c} = asr_w;
      OP_OR:          sc_s = a | b;
      OP_AND:         sc_s = a & b;
      OP_XOR:         sc_s = a ^ b;
      OP_NOT:         sc_s = ~a;
      OP_ADD: begin
        {sc_c, sc_s} = add_w;
        sc_v = (a[bus-1] == b[bus-1]) && (add_w[bus-1] != a[bus-1]);
      end
      OP_SUB: begin
        {sc_c, sc_s} = sub_w;
        sc_v = (a[bus-1] != b[bus-1]) && (sub_w[bus-1] != a[bus-1]);
      end
      default: ;
    endcase
  end

  // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand into hi and shift right.
  // Divide: {hi,lo} starts as {0, dividend}; hi is the partial remainder, lo fills with quotient bits.
  logic [bus:0]    mul_sum;
  logic [bus:0]    div_shift;
  logic [bus-1:0]  div_sub;
  logic            div_ge;
  logic            is_mul;
  logic [bus-1:0]  hi_nx, lo_nx;
  logic [bus-1:0]  mc_s;
  logic            mc_c, mc_v;

  assign is_mul    = (op_q == OP_MUL);
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi, lo[bus-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[bus-1:0] - opnd_q;
  assign hi_nx     = is_mul ? mul_sum[bus:1] : (div_ge ? div_sub : div_shift[bus-1:0]);
  assign lo_nx     = is_mul ? {mul_sum[0], lo[bus-1:1]} : {lo[bus-2:0], div_ge};
  assign mc_s      = (op_q == OP_MODU) ? hi_nx : lo_nx;
  assign mc_c      = is_mul && (hi_nx != '0);
  assign mc_v      = is_mul ? (hi_nx != '0) : (opnd_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      CNVZ      <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (is_multi) begin
              op_q   <= ALUFUN;
              opnd_q <= (ALUFUN == OP_MUL) ? a : b;
              hi     <= '0;
              lo     <= (ALUFUN == OP_MUL) ? b : a;
              cnt    <= '0;
              state  <= BUSY;
            end else begin
              s         <= sc_s;
              CNVZ      <= {sc_c, sc_s[bus-1], sc_v, sc_s == '0};
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + SW'(1);
          if (cnt == SW'(bus-1)) begin
            s         <= mc_s;
            CNVZ      <= {mc_c, mc_s[bus-1], mc_v, mc_s == '0};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (bus=8) against an
// arithmetic reference model.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, s;
  logic [3:0] ALUFUN, CNVZ;
  logic       in_valid, in_ready, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.bus(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ALUFUN(ALUFUN),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .CNVZ(CNVZ), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, sh, r, full;
    bit c, v;
    ua = x; ub = y; sa = int'($signed(x)); sb = int'($signed(y));
    sh = ub % 8; r = 0; c = 0; v = 0;
    case (op)
      4'h0, 4'h2: begin full = ua * (1 << sh); r = full % 256; c = (sh != 0) && ((full / 256) % 2 == 1); end
      4'h1: begin r = ua / (1 << sh); c = (sh == 0) ? 1'b0 : ((ua / (1 << (sh - 1))) % 2 == 1); end
      4'h3: begin r = (sa >>> sh) & 255; c = (sh == 0) ? 1'b0 : ((ua / (1 << (sh - 1))) % 2 == 1); end
      4'h4: r = ua | ub;
      4'h5: r = ua & ub;
      4'h6: r = ua ^ ub;
      4'h7: r = 255 - ua;
      4'h8: begin full = ua + ub; r = full % 256; c = full > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      4'h9: begin full = ua + (255 - ub) + 1; r = full % 256; c = full > 255; v = (sa - sb > 127) || (sa - sb < -128); end
      4'hA: begin full = ua * ub; r = full % 256; c = full > 255; v = c; end
      4'hB: if (ub == 0) begin r = 255; v = 1; end else r = ua / ub;
      4'hC: if (ub == 0) begin r = ua; v = 1; end else r = ua % ub;
      default: r = 0;
    endcase
    return {8'(r), c, r >= 128, v, r == 0};
  endfunction

  // Drives one request, scrambles the inputs after acceptance, and reports
  // the result and how many cycles after acceptance out_valid appeared (0 = timeout).
  task automatic run_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib, input int hold,
                        output logic [7:0] rs, output logic [3:0] rf, output int lat, output bit rdy_seen);
    int n = 0;
    rs = 8'hxx; rf = 4'hx; lat = 0; rdy_seen = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) return;
    ALUFUN = op; a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); ALUFUN = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) rdy_seen = 1;
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) begin lat = 0; return; end
    rs = s; rf = CNVZ;
    repeat (hold) begin
      if (in_ready !== 1'b0) rdy_seen = 1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, s, CNVZ} !== 14'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b s=%h CNVZ=%b, want all 0", in_ready, out_valid, s, CNVZ);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b, want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [35:0] tbl [12];
    logic [7:0] rs; logic [3:0] rf; int lat; bit rdy;
    tbl = '{{4'h8, 8'h7F, 8'h01, 8'h80, 4'h6, 4'd1},
            {4'h9, 8'h05, 8'h05, 8'h00, 4'h9, 4'd1},
            {4'h9, 8'h00, 8'h01, 8'hFF, 4'h4, 4'd1},
            {4'hA, 8'h10, 8'h10, 8'h00, 4'hB, 4'd9},
            {4'hB, 8'h64, 8'h07, 8'h0E, 4'h0, 4'd9},
            {4'hC, 8'h64, 8'h07, 8'h02, 4'h0, 4'd9},
            {4'hB, 8'h64, 8'h00, 8'hFF, 4'h6, 4'd9},
            {4'hC, 8'h64, 8'h00, 8'h64, 4'h2, 4'd9},
            {4'h0, 8'h81, 8'h08, 8'h81, 4'h4, 4'd1},
            {4'h0, 8'h81, 8'h01, 8'h02, 4'h8, 4'd1},
            {4'hE, 8'h55, 8'hAA, 8'h00, 4'h1, 4'd1},
            {4'h7, 8'h0F, 8'h00, 8'hF0, 4'h4, 4'd1}};
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i][35:32], tbl[i][31:24], tbl[i][23:16], i % 3, rs, rf, lat, rdy);
      checks++;
      if (rs !== tbl[i][15:8] || rf !== tbl[i][7:4] || lat != int'(tbl[i][3:0]) || rdy) begin
        errors++;
        $display("FAIL directed_%0d op=%h: s=%h CNVZ=%b lat=%0d in_ready_seen=%0d, want s=%h CNVZ=%b lat=%0d in_ready_seen=0",
                 i, tbl[i][35:32], rs, rf, lat, rdy, tbl[i][15:8], tbl[i][7:4], tbl[i][3:0]);
      end
    end
  endtask

  task automatic test_hold();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    ALUFUN = 4'h3; a = 8'h81; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, s, CNVZ} !== {1'b1, 8'hC0, 4'hC}) begin
      errors++; $display("FAIL hold_asr: out_valid=%b s=%h CNVZ=%b, want 1 c0 1100", out_valid, s, CNVZ);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); ALUFUN = 4'h8; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, s, CNVZ} !== {1'b1, 1'b0, 8'hC0, 4'hC}) begin
        errors++; $display("FAIL hold_stable_%0d: out_valid=%b in_ready=%b s=%h CNVZ=%b, want 1 0 c0 1100", i, out_valid, in_ready, s, CNVZ);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_accept: out_valid=%b, want 0", out_valid); end
  endtask

  task automatic test_reset_busy();
    logic [7:0] rs; logic [3:0] rf; int lat; bit rdy; int seen = 0; int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    ALUFUN = 4'hA; a = 8'h10; b = 8'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, s, CNVZ, in_ready} !== 14'b0) begin
      errors++; $display("FAIL busy_reset: out_valid=%b s=%h CNVZ=%b in_ready=%b, want all 0", out_valid, s, CNVZ, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_reset_release: in_ready=%b, want 1", in_ready); end
    repeat (12) begin if (out_valid !== 1'b0) seen++; @(posedge clk); #1; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL busy_reset_abort: out_valid high %0d cycles, want 0", seen); end
    run_op(4'h8, 8'h02, 8'h03, 0, rs, rf, lat, rdy);
    checks++;
    if (rs !== 8'h05 || rf !== 4'h0 || lat != 1) begin
      errors++; $display("FAIL busy_reset_fresh_add: s=%h CNVZ=%b lat=%0d, want 05 0000 1", rs, rf, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] rs, ea, eb; logic [3:0] rf, op; logic [11:0] exp; int lat, elat; bit rdy;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15)); ea = 8'($urandom); eb = 8'($urandom);
      if ($urandom_range(0, 4) == 0) eb = 8'h00;
      exp = model(op, ea, eb);
      elat = (op == 4'hA || op == 4'hB || op == 4'hC) ? 9 : 1;
      run_op(op, ea, eb, $urandom_range(0, 3), rs, rf, lat, rdy);
      checks++;
      if ({rs, rf} !== exp || lat != elat || rdy) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h: s=%h CNVZ=%b lat=%0d rdy=%0d, want s=%h CNVZ=%b lat=%0d rdy=0",
                 i, op, ea, eb, rs, rf, lat, rdy, exp[11:4], exp[3:0], elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rs, ea, eb; logic [3:0] rf, op; logic [11:0] exp; int lat, elat; bit rdy;
    for (int i = 0; i < 20; i++) begin
      op = (i % 2 == 0) ? 4'(8 + $urandom_range(0, 4)) : 4'($urandom_range(0, 7));
      ea = 8'($urandom); eb = 8'($urandom);
      exp = model(op, ea, eb);
      elat = (op == 4'hA || op == 4'hB || op == 4'hC) ? 9 : 1;
      run_op(op, ea, eb, 0, rs, rf, lat, rdy);
      checks++;
      if ({rs, rf} !== exp || lat != elat || rdy) begin
        errors++;
        $display("FAIL b2b_%0d op=%h a=%h b=%h: s=%h CNVZ=%b lat=%0d rdy=%0d, want s=%h CNVZ=%b lat=%0d rdy=0",
                 i, op, ea, eb, rs, rf, lat, rdy, exp[11:4], exp[3:0], elat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; ALUFUN = 4'h0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: bus, 8, operand/result width; power of two, 4..32.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: a  input  bus  operand A, sampled on acceptance.
REQ-005 SHALL have port: b  input  bus  operand B or shift amount, sampled on acceptance.
REQ-006 SHALL have port: ALUFUN  input  4  operation code, sampled on acceptance.
REQ-007 SHALL have port: in_valid  input  1  request present.
REQ-008 SHALL have port: in_ready  output  1  block can accept a request.
REQ-009 SHALL have port: s  output  bus  registered result.
REQ-010 SHALL have port: CNVZ  output  4  registered flags: [3]=C, [2]=N, [1]=V, [0]=Z.
REQ-011 SHALL have port: out_valid  output  1  s/CNVZ hold a valid result.
REQ-012 SHALL have port: out_ready  input  1  consumer takes the result.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-015 SHALL accept a request when in_valid and in_ready are both high at a rising edge; in_valid SHALL be ignored in every other state.
REQ-016 SHALL decode ALUFUN as: 0000 LSL, 0001 LSR, 0010 ASL (=LSL), 0011 ASR, 0100 OR, 0101 AND, 0110 XOR, 0111 NOT a, 1000 ADD, 1001 SUB (a-b), 1010 MUL, 1011 DIVU, 1100 MODU; 1101-1111 reserved.
REQ-017 SHALL complete single-cycle ops (all except MUL/DIVU/MODU) by going IDLE->DONE, with out_valid high in the cycle after acceptance.
REQ-018 SHALL run MUL, DIVU and MODU in BUSY for exactly bus cycles (shift-add multiply; restoring divide, one bit per cycle), then enter DONE, giving out_valid bus+1 cycles after acceptance.
REQ-019 SHALL hold s, CNVZ and out_valid stable in DONE until out_ready is high at an edge, then return to IDLE; no request is accepted in that same cycle.
REQ-020 SHALL take the shift amount as b[clog2(bus)-1:0]; shift by 0 gives s=a with C=0; otherwise C = last bit shifted out.
REQ-021 SHALL produce, for ADD, s=(a+b) mod 2^bus, C=carry out, V=signed overflow.
REQ-022 SHALL produce, for SUB, s=a+~b+1, C=carry out (1 = no borrow), V=signed overflow of a-b.
REQ-023 SHALL produce, for MUL, s=low bus bits of the unsigned product; C=V=1 iff the high half is nonzero.
REQ-024 SHALL produce, for DIVU, s=unsigned a/b; for MODU, s=a mod b; C=V=0 when b is nonzero.
REQ-025 SHALL handle divide-by-zero as: DIVU s=all ones, MODU s=a, V=1, C=0.
REQ-026 SHALL force C=V=0 for logic ops.
REQ-027 SHALL compute N=s[bus-1] and Z=(s==0) for every op.
REQ-028 SHALL produce, for reserved codes, a single-cycle result s=0, CNVZ=0001.
REQ-029 SHALL base results only on operands latched at acceptance; input changes during BUSY/DONE SHALL have no effect.

Reset
REQ-030 SHALL, with rst high at an edge, enter IDLE and clear s=0, CNVZ=0000, out_valid=0 and all internal datapath registers.
REQ-031 SHALL keep in_ready low while rst is high and raise it in the first cycle after rst deasserts.
REQ-032 SHALL, on rst during BUSY or DONE, abort the operation and produce no out_valid for it.

Verification (bus=8)
REQ-033 SHALL be verified by: ADD a=0x7F, b=0x01 -> s=0x80, CNVZ=0110, out_valid one cycle after acceptance.
REQ-034 SHALL be verified by: SUB a=0x05, b=0x05 -> s=0x00, CNVZ=1001; SUB a=0x00, b=0x01 -> s=0xFF, CNVZ=0100.
REQ-035 SHALL be verified by: MUL a=0x10, b=0x10 -> s=0x00, CNVZ=1011, out_valid exactly 9 cycles after acceptance, in_ready low throughout.
REQ-036 SHALL be verified by: DIVU 0x64/0x07 -> s=0x0E; MODU -> s=0x02; DIVU 0x64/0x00 -> s=0xFF, V=1; MODU 0x64/0x00 -> s=0x64.
REQ-037 SHALL be verified by: holding out_ready low 5 cycles after an ASR a=0x81, b=0x01 (s=0xC0, CNVZ=1100) -> s/CNVZ stable, in_valid pulses ignored, IDLE on the first out_ready edge.
REQ-038 SHALL be verified by: rst high at the 4th BUSY cycle of a MUL -> next cycle out_valid=0, s=0, CNVZ=0000; in_ready=1 the cycle after rst deasserts; a fresh ADD 2+3 gives s=0x05.
